univ_shift_reg_dr: RTL and testbench
====================================

// Module: univ_shift_reg_dr
// PURPOSE
// - Parametrised universal shift register built from dual-rail flip-flop cells.
//   Every stage drives both a true output (q) and a complement output (qn).
// - Modes: hold, shift right, shift left, parallel load, each with optional rotate.
// - A shift counter flags each completed word, i.e. WIDTH consecutive same-direction
//   shifts, for serial<->parallel conversion.
// - Sits between the serial link front-end and the parallel datapath of the register file.
// PARAMETERS
// - WIDTH    4   number of stages (>=2)
// - CNT_W    3   shift-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
// - clk        in   1      rising-edge clock, single clock domain
// - rst        in   1      asynchronous, active-high reset
// - en         in   1      1: apply mode this edge; 0: hold everything (counter included)
// - mode       in   2      00 hold, 01 shift right, 10 shift left, 11 parallel load
// - rot        in   1      1: shifts rotate (serial inputs ignored)
// - sir        in   1      serial in for shift right; enters q[WIDTH-1]
// - sil        in   1      serial in for shift left; enters q[0]
// - d          in   WIDTH  parallel load data
// - q          out  WIDTH  register contents, true rail
// - qn         out  WIDTH  register contents, complement rail
// - so_r       out  1      serial out for right shifts (= q[0])
// - so_l       out  1      serial out for left shifts (= q[WIDTH-1])
// - word_done  out  1      one-cycle pulse: WIDTH consecutive shifts completed
// BEHAVIOUR
// - Reset (async, on rst=1, held while high): q=0, qn={WIDTH{1}}, count=0,
//   last_dir=right, word_done=0. Deassertion is sampled at the next rising clk.
// - All state updates on rising clk when rst=0 and en=1. Latency: one edge.
// - Result visible on q/qn right after that edge.
// - Shift right: q <= {rot ? q[0] : sir, q[WIDTH-1:1]}.
// - Shift left:  q <= {q[WIDTH-2:0], rot ? q[WIDTH-1] : sil}.
// - Load: q <= d; count <= 0. Hold: q, count and last_dir unchanged.
// - qn is a separately registered rail, loaded with the complement of the next q.
//   Invariant on every cycle, including across reset: qn == ~q.
// - so_r/so_l are combinational from q (no extra delay).
// - Counter on a shift:
//   - Same direction as last_dir: count <= count+1.
//   - Direction change: count <= 1.
//   - last_dir <= current direction.
// - When a shift makes count reach WIDTH:
//   - count <= 0 on that edge.
//   - word_done is 1 for exactly the following cycle (registered).
// - word_done is 0 in every other cycle, including on en=0, hold and load.
// - Rotate shifts count identically to normal shifts.
// - Simultaneous events:
//   - mode is the only selector; sir, sil and d are don't-care outside their mode.
//   - rot is ignored for hold and load.
// - en=0 with a pending word_done: the pulse still lasts exactly one cycle.
// - Reset mid-word clears count and word_done immediately (asynchronously).
//   The partial word is discarded.
// - No X-propagation tolerance required: X on mode with en=1 is a bench error.
// TESTING (WIDTH=4)
// 1. Reset: assert rst mid-cycle -> q=0000 and qn=1111 immediately, word_done=0.
//    Release -> state held until the first en=1 edge.
// 2. Load d=1011, then shift right 4x with sir=1,0,0,1:
//    - q sequence: 1101, 0110, 0011, 1001.
//    - so_r before each edge: 1,1,0,1.
//    - word_done=1 only in the cycle after the 4th edge.
// 3. Load 1000, rot=1, shift left 4x:
//    - q sequence: 0001, 0010, 0100, 1000.
//    - word_done pulses once after the 4th shift.
// 4. Shift right 3x, shift left 1x, shift left 3x more:
//    - No pulse after shift 4.
//    - word_done pulses after the 4th consecutive left shift (the 7th shift overall).
// 5. Shift right 2x, en=0 for 5 cycles, shift right 2x:
//    - word_done after the last shift.
//    - q frozen during en=0.
// 6. Shift 2x, then assert rst:
//    - q=0000 and count=0.
//    - After release, 3 shifts give no pulse; the 4th gives word_done=1.
//    - qn==~q checked every cycle in all tests.

Source files
------------

// File: rtl/univ_shift_reg_dr.sv
// Universal shift register with dual-rail (q/qn) stage outputs and a word counter
// that pulses word_done after WIDTH consecutive same-direction shifts.
module univ_shift_reg_dr #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             sir,
  input  logic             sil,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             so_r,
  output logic             so_l,
  output logic             word_done
);

  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;
  localparam logic       DIR_RIGHT  = 1'b0;
  localparam logic       DIR_LEFT   = 1'b1;

  logic [CNT_W-1:0] count, count_nxt, count_inc;
  logic             last_dir, last_dir_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             done_nxt;
  logic             shift, dir;

  // Next-state: data path first, then the run-length counter for shifts
  always_comb begin
    q_nxt        = q;
    count_nxt    = count;
    last_dir_nxt = last_dir;
    done_nxt     = 1'b0;
    shift        = 1'b0;
    dir          = DIR_RIGHT;
    count_inc    = '0;
    if (en) begin
      case (mode)
        MODE_RIGHT: begin
          q_nxt = {(rot ? q[0] : sir), q[WIDTH-1:1]};
          shift = 1'b1;
          dir   = DIR_RIGHT;
        end
        MODE_LEFT: begin
          q_nxt = {q[WIDTH-2:0], (rot ? q[WIDTH-1] : sil)};
          shift = 1'b1;
          dir   = DIR_LEFT;
        end
        MODE_LOAD: begin
          q_nxt     = d;
          count_nxt = '0;
        end
        default: ;
      endcase
    end
    if (shift) begin
      count_inc    = (dir == last_dir) ? CNT_W'(count + CNT_W'(1)) : CNT_W'(1);
      last_dir_nxt = dir;
      if (count_inc == CNT_W'(WIDTH)) begin
        count_nxt = '0;
        done_nxt  = 1'b1;
      end else begin
        count_nxt = count_inc;
      end
    end
  end

  // qn is its own register, loaded with the complement of the next q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q         <= '0;
      qn        <= '1;
      count     <= '0;
      last_dir  <= DIR_RIGHT;
      word_done <= 1'b0;
    end else begin
      q         <= q_nxt;
      qn        <= ~q_nxt;
      count     <= count_nxt;
      last_dir  <= last_dir_nxt;
      word_done <= done_nxt;
    end
  end

  assign so_r = q[0];
  assign so_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg_dr.sv
// Bench for univ_shift_reg_dr: directed scenarios plus randomized traffic, all
// checked against an arithmetic model of the register and its shift-run counter.
module tb_univ_shift_reg_dr;

  localparam int unsigned W    = 4;
  localparam int          MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         rot = 1'b0;
  logic         sir = 1'b0;
  logic         sil = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] q, qn;
  logic         so_r, so_l, word_done;

  int vectors = 0;
  int miscompares = 0;

  // model state
  int m_q = 0;
  int m_run = 0;
  bit m_left = 0;
  bit m_done = 0;

  univ_shift_reg_dr #(.WIDTH(W), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot), .sir(sir), .sil(sil),
    .d(d), .q(q), .qn(qn), .so_r(so_r), .so_l(so_l), .word_done(word_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("q", int'(q), m_q);
    check("qn", int'(qn), (~m_q) & MASK);
    check("qn_inv", int'(qn ^ q), MASK);
    check("word_done", int'(word_done), int'(m_done));
    check("so_r", int'(so_r), m_q & 1);
    check("so_l", int'(so_l), (m_q >> (W - 1)) & 1);
  endtask

  // Reference behaviour for one clock edge
  task automatic model_edge(input bit e, input int md, input bit r, input bit s_r,
                            input bit s_l, input int dd);
    bit in_bit, left;
    m_done = 0;
    if (e && md == 3) begin
      m_q   = dd & MASK;
      m_run = 0;
    end else if (e && (md == 1 || md == 2)) begin
      left = (md == 2);
      if (left) begin
        in_bit = r ? bit'((m_q >> (W - 1)) & 1) : s_l;
        m_q    = ((m_q << 1) | int'(in_bit)) & MASK;
      end else begin
        in_bit = r ? bit'(m_q & 1) : s_r;
        m_q    = (m_q >> 1) | (int'(in_bit) << (W - 1));
      end
      m_run  = (left == m_left) ? m_run + 1 : 1;
      m_left = left;
      if (m_run == W) begin
        m_done = 1;
        m_run  = 0;
      end
    end
  endtask

  task automatic step(input bit e, input logic [1:0] md, input bit r, input bit s_r,
                      input bit s_l, input logic [W-1:0] dd);
    en = e; mode = md; rot = r; sir = s_r; sil = s_l; d = dd;
    @(posedge clk);
    model_edge(e, int'(md), r, s_r, s_l, int'(dd));
    #1;
    check_all();
  endtask

  // Mid-cycle asynchronous reset, held across one edge
  task automatic do_reset();
    #3 rst = 1'b1;
    #1;
    check("rst_q", int'(q), 0);
    check("rst_qn", int'(qn), MASK);
    check("rst_wd", int'(word_done), 0);
    m_q = 0; m_run = 0; m_left = 0; m_done = 0;
    @(posedge clk);
    #1;
    check_all();
    #2 rst = 1'b0;
  endtask

  logic [W-1:0] exp_q [4];
  logic         exp_so [4];
  logic         bits [4];

  initial begin
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_all();

    // 1: mid-cycle reset, then hold until enabled
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0110);
    do_reset();
    step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1111);
    step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 4'b1111);

    // 2: load 1011, shift right with sir=1,0,0,1
    exp_q  = '{4'b1101, 4'b0110, 4'b0011, 4'b1001};
    exp_so = '{1'b1, 1'b1, 1'b0, 1'b1};
    bits   = '{1'b1, 1'b0, 1'b0, 1'b1};
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1011);
    for (int i = 0; i < 4; i++) begin
      check("t2_so_r", int'(so_r), int'(exp_so[i]));
      step(1'b1, 2'b01, 1'b0, bits[i], 1'b0, 4'b0000);
      check("t2_q", int'(q), int'(exp_q[i]));
      check("t2_wd", int'(word_done), (i == 3) ? 1 : 0);
    end
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000);
    check("t2_wd_after", int'(word_done), 0);

    // 3: load 1000, rotate left 4x
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 4'b0000);
      check("t3_q", int'(q), int'(exp_q[i]));
      check("t3_wd", int'(word_done), (i == 3) ? 1 : 0);
    end

    // 4: direction change restarts the run
    for (int i = 0; i < 7; i++) begin
      step(1'b1, (i < 3) ? 2'b01 : 2'b10, 1'b0, 1'($urandom), 1'($urandom), 4'b0000);
      check("t4_wd", int'(word_done), (i == 6) ? 1 : 0);
    end

    // 5: en=0 gap freezes both data and count
    for (int i = 0; i < 9; i++) begin
      step((i < 2 || i > 6) ? 1'b1 : 1'b0, 2'b01, 1'b0, 1'($urandom), 1'b0,
           4'($urandom));
      check("t5_wd", int'(word_done), (i == 8) ? 1 : 0);
    end

    // 6: reset mid-word discards the partial count
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 4'b0000);
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 4'b0000);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 4'b0000);
      check("t6_wd", int'(word_done), (i == 3) ? 1 : 0);
    end

    // randomized traffic, occasional resets
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      else step(($urandom_range(0, 5) != 0), 2'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
